// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with write-to-read bypass and pending-write scoreboard
//   clk, rst_n             clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_ready  NUM_RD packed read ports (address, operand, operand-valid)
//   wr_en/wr_addr/wr_data  writeback port
//   alloc_en/alloc_addr    destination allocation from decode (marks register pending)
//   flush                  clears every pending bit
//   pend_cnt               registered count of pending registers
//   alloc_hit              alloc_addr already pending (WAW warning)
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     alloc_hit
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR = ZERO_REG != 0;
    localparam bit BP = BYPASS != 0;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend, pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_ok;
    assign wr_ok = wr_en && !(ZR && wr_addr == '0);
    assign alloc_hit = alloc_en && pend[alloc_addr] && !(ZR && alloc_addr == '0);
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              z, b;
        assign a = rd_addr[i*ADDR_W +: ADDR_W];
        assign z = ZR && a == '0;
        assign b = BP && wr_en && wr_addr == a;
        assign rd_data[i*DATA_W +: DATA_W] = z ? '0 : b ? wr_data : regs[a];
        assign rd_ready[i] = z || b || !pend[a];
    end
    // allocation outranks a same-cycle writeback: the younger instruction owns the register
    always_comb begin
        pend_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            pend_nxt[r] = (flush || (ZR && r == 0)) ? 1'b0 :
                          (alloc_en && alloc_addr == ADDR_W'(r)) ? 1'b1 :
                          (wr_en && wr_addr == ADDR_W'(r)) ? 1'b0 : pend[r];
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed scoreboard bench for regfile_mp_sb (default parameters)
module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        wr_en, alloc_en, flush, alloc_hit;
    logic [4:0]  wr_addr, alloc_addr;
    logic [31:0] wr_data;
    logic [5:0]  pend_cnt;

    typedef struct {
        string       name;
        logic [31:0] d0, d1;
        logic [1:0]  r;
        logic [5:0]  c;
        logic        h;
    } exp_t;
    exp_t q[$];
    int n_vec = 0, n_err = 0;

    regfile_mp_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .pend_cnt(pend_cnt), .alloc_hit(alloc_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
        end
    endtask

    // monitor: samples 3 time units after the negedge on which stimulus was applied
    always @(negedge clk) begin
        #3;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "rd_data0", rd_data[31:0], e.d0);
            chk(e.name, "rd_data1", rd_data[63:32], e.d1);
            chk(e.name, "rd_ready", {30'd0, rd_ready}, {30'd0, e.r});
            chk(e.name, "pend_cnt", {26'd0, pend_cnt}, {26'd0, e.c});
            chk(e.name, "alloc_hit", {31'd0, alloc_hit}, {31'd0, e.h});
        end
    end

    task automatic vec(input string n, input logic rs, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ae, input logic [4:0] aa, input logic fl,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] r,
                       input logic [5:0] c, input logic h);
        exp_t e;
        @(negedge clk);
        rst_n = rs; rd_addr = {a1, a0};
        wr_en = we; wr_addr = wa; wr_data = wd;
        alloc_en = ae; alloc_addr = aa; flush = fl;
        e.name = n; e.d0 = d0; e.d1 = d1; e.r = r; e.c = c; e.h = h;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b1; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        alloc_en = 0; alloc_addr = '0; flush = 0;
        #1 rst_n = 1'b0;
        //   name          rs a0 a1 we wa wd            ae aa fl  d0            d1            r      c  h
        vec("in_reset",    0, 5, 5, 0, 0, 0,            0, 0, 0, 0,            0,            2'b11, 0, 0);
        vec("reset",       1, 5, 5, 0, 0, 0,            0, 0, 0, 0,            0,            2'b11, 0, 0);
        vec("bypass",      1, 5, 3, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0,            32'hDEADBEEF, 2'b11, 0, 0);
        vec("stored",      1, 3, 3, 0, 0, 0,            0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0, 0);
        vec("alloc7",      1, 7, 3, 0, 0, 0,            1, 7, 0, 0,            32'hDEADBEEF, 2'b11, 0, 0);
        vec("pend7",       1, 7, 7, 0, 0, 0,            0, 0, 0, 0,            0,            2'b00, 1, 0);
        vec("wb7",         1, 7, 0, 1, 7, 32'h12,       0, 0, 0, 32'h12,       0,            2'b11, 1, 0);
        vec("clear7",      1, 7, 7, 0, 0, 0,            0, 0, 0, 32'h12,       32'h12,       2'b11, 0, 0);
        vec("alloc9",      1, 9, 7, 0, 0, 0,            1, 9, 0, 0,            32'h12,       2'b11, 0, 0);
        vec("waw9",        1, 9, 9, 1, 9, 32'hCAFE0009, 1, 9, 0, 32'hCAFE0009, 32'hCAFE0009, 2'b11, 1, 1);
        vec("held9",       1, 9, 9, 0, 0, 0,            0, 0, 0, 32'hCAFE0009, 32'hCAFE0009, 2'b00, 1, 0);
        vec("zero_wr",     1, 0, 9, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,            32'hCAFE0009, 2'b01, 1, 0);
        vec("zero_after",  1, 0, 0, 0, 0, 0,            0, 0, 0, 0,            0,            2'b11, 1, 0);
        for (int k = 1; k <= 4; k++)
            vec($sformatf("alloc%0d", k), 1, 5'(k), 9, 0, 0, 0, 1, 5'(k), 0,
                (k == 3) ? 32'hDEADBEEF : 32'h0, 32'hCAFE0009, 2'b01, 6'(k), 0);
        vec("pend1_4",     1, 4, 1, 0, 0, 0,            0, 0, 0, 0,            0,            2'b00, 5, 0);
        vec("flush",       1, 6, 2, 0, 0, 0,            1, 6, 1, 0,            0,            2'b01, 5, 0);
        vec("post_flush",  1, 6, 9, 0, 0, 0,            0, 0, 0, 0,            32'hCAFE0009, 2'b11, 0, 0);
        vec("alloc8",      1, 8, 9, 0, 0, 0,            1, 8, 0, 0,            32'hCAFE0009, 2'b11, 0, 0);
        vec("pend8",       1, 8, 3, 0, 0, 0,            1, 8, 0, 0,            32'hDEADBEEF, 2'b10, 1, 1);
        vec("async_rst",   0, 3, 9, 0, 0, 0,            0, 0, 0, 0,            0,            2'b11, 0, 0);
        vec("post_rst",    1, 8, 7, 0, 0, 0,            0, 0, 0, 0,            0,            2'b11, 0, 0);
        @(negedge clk);
        #5;
        chk("drain", "queue", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
